lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator that sits between the core's memory stage and the word-organised data memory.
- Data memory: 2^ADDR_W x 32-bit words, asynchronous read, write on clk_i posedge when wren is high.
- Accepts byte/half/word load and store requests via a valid/ready handshake; drives word address, write data and write enable.
- Sub-word stores are done as read-modify-write, because the memory has only full-word write enable.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
ADDR_W, 10, word-address width of the data memory (4 KiB at default)
XLEN, 32, data width; fixed at 32, present for package consistency

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  LSU can accept a request (high only in IDLE)
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
req_unsigned_i  in  1  zero-extend the load result
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned, out-of-range or reserved size; valid with rsp_valid_o
mem_addr_o  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata_o  out  32  full word to write
mem_wren_o  out  1  memory write enable
mem_rdata_i  in  32  memory read data (asynchronous, same cycle)

Behaviour:
- Reset (rst_i high at a posedge):
  - state becomes IDLE; req_ready_o 1.
  - rsp_valid_o, rsp_err_o, mem_wren_o 0; rsp_rdata_o, mem_addr_o, mem_wdata_o 0.
  - mem_wren_o is gated by !rst_i, so no memory write occurs at a reset edge, even when reset arrives in WR.
  - Reset mid-operation abandons the request with no response.
- Handshake: a request is accepted at a posedge with req_valid_i && req_ready_o. The request is latched, state leaves IDLE, and req_ready_o drops until RESP completes.
- States:
  - IDLE -> RESP: on accept with error.
  - IDLE -> WR: on accept, word store.
  - IDLE -> RD: on accept, load or sub-word store.
  - RD -> RESP: load. RD captures mem_rdata_i at the end of the cycle.
  - RD -> WR: sub-word store.
  - WR -> RESP.
  - RESP -> IDLE. rsp_valid_o is high for exactly the RESP cycle.
- Latency from the accept edge T:
  - load: response at T+2.
  - word store: WR at T+1, response at T+2.
  - sub-word store: RD at T+1, WR at T+2, response at T+3.
  - error: response at T+1.
  - Back-to-back: the next accept is possible in the cycle after RESP.
- Errors (rsp_err_o = 1, no memory access):
  - size 11;
  - half with addr[0] = 1; word with addr[1:0] != 0 (misalignment rule: see Optional Feature);
  - addr[31:ADDR_W+2] != 0.
- Load extract:
  - byte lane = addr[1:0]; half lane = addr[1].
  - sign-extend from bit 7/15 unless req_unsigned_i.
  - word: pass-through; req_unsigned_i ignored.
- Store merge:
  - mem_wdata_o = captured word with the selected byte/half lane replaced by req_wdata_i[7:0]/[15:0].
  - other bits are preserved exactly.
  - word store writes req_wdata_i unchanged.
- Signal timing:
  - mem_addr_o holds the latched word address from RD through WR.
  - mem_wren_o is high only in WR.
  - rsp_rdata_o is 0 on store responses and on error responses.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned half/word requests are reported with rsp_err_o = 1, as above.
- Undefined: misalignment is not an error. The low address bits are forced to alignment (half: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds normally. rsp_err_o is raised only for reserved size or out-of-range.

Decomposition:
- lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_RSV);
  - state enum (IDLE, RD, WR, RESP);
  - XLEN constant;
  - default ADDR_W constant.
- Sub-module lsu_align: purely combinational.
  - Load extract: word, offset, size, unsigned -> data.
  - Store merge: old word, new data, offset, size -> word.
  - Instantiated once, so both paths are unit-testable.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x010 -> WR at T+1 with mem_addr_o = 4 and mem_wren_o = 1; load 0x010 -> rsp_rdata_o = 0xDEADBEEF at T+2, rsp_err_o = 0.
- Byte store RMW: memory word 4 = 0x11223344; store byte 0xAA at 0x012 -> written word 0x11AA3344, response at T+3.
- Signed/unsigned load: word = 0x0000F080; lb 0x010 -> 0xFFFFFF80; lbu 0x010 -> 0x00000080; lh 0x010 -> 0xFFFFF080; lhu -> 0x0000F080.
- Errors, no write:
  - word load at 0x013 -> rsp_err_o = 1 at T+1 with LSU_MISALIGN_TRAP_EN;
  - without it -> data of word 4, no error;
  - address 0x1000 -> error in both builds.
- Reset mid-RMW: rst_i high in the WR cycle of a byte store -> memory word unchanged, no rsp_valid_o, req_ready_o = 1 on the next cycle.
- Back-to-back: requests held valid continuously -> accepts spaced exactly by the latency + 1, rsp_valid_o never high two cycles in a row.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and constants for the load/store memory master.
//             Access-size encoding, FSM state encoding, data width and the
//             default word-address width of the data memory.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_W_DEF = 10;

  // Access size as carried on req_size_i.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } lsu_size_e;

  // FSM state encoding (plain constants, kept legacy-tool friendly).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_master_if
//  Purpose  : Bundles the request/response handshake and the data-memory
//             bus of the load/store master.
//  Ports    : req_*  - request from the core memory stage
//             rsp_*  - one-cycle response back to the core
//             mem_*  - word-organised data memory (async read)
//  Modports : master - the LSU itself (drives req_ready, rsp_*, mem_addr/
//                      wdata/wren)
//             slave  - the environment (core + memory)
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_master_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_wren_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_wdata_o, mem_wren_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_wdata_o, mem_wren_o
  );

endinterface : lsu_mem_master_if
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Purely combinational lane logic for the load/store master.
//             Load extract : picks the byte/half lane out of a memory word
//                            and sign- or zero-extends it.
//             Store merge  : replaces the selected byte/half lane of an old
//                            word with new data, keeping every other bit.
//  Ports    : word_i   - memory word (load source / merge base)
//             wdata_i  - new store data, right-aligned (low 16 bits used)
//             off_i    - byte offset within the word
//             size_i   - access size
//             uns_i    - zero-extend load result
//             load_o   - extended load data
//             merge_o  - merged store word
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  wire logic [31:0] word_i,
  input  wire logic [15:0] wdata_i,
  input  wire logic [1:0]  off_i,
  input  wire lsu_size_e   size_i,
  input  wire logic        uns_i,
  output logic      [31:0] load_o,
  output logic      [31:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = 8'h00;
    w_half  = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = word_i;

    case (off_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase

    case (size_i)
      SZ_B: begin
        load_o = uns_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        load_o = uns_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      // Word accesses pass straight through; the reserved size never
      // reaches a memory access.
      default: begin
        load_o  = word_i;
        merge_o = word_i;
      end
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_master
//  Purpose  : Load/store initiator between the core memory stage and a
//             word-organised, async-read data memory. Byte/half stores are
//             read-modify-write because the memory only has a word enable.
//  Ports    : clk_i, rst_i (sync, active-high)
//             bus (lsu_mem_master_if.master) - request, response, memory
//  Macro    : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//             accesses respond with an error; when undefined the low
//             address bits are forced to alignment and the access proceeds.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int XLEN   = lsu_pkg::XLEN
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  lsu_mem_master_if.master  bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  lsu_size_e         size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [15:0]       wlo_q, wlo_d;
  logic [XLEN-1:0]   wword_q, wword_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              w_accept;
  lsu_size_e         w_req_size;
  logic              w_out_of_range;
  logic              w_req_err;
  logic [ADDR_W+1:0] w_req_addr;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_merge;

  assign w_accept       = bus.req_valid_i && (state_q == ST_IDLE);
  assign w_req_size     = lsu_size_e'(bus.req_size_i);
  assign w_out_of_range = |(bus.req_addr_i >> (ADDR_W + 2));

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_req_size == SZ_H) && bus.req_addr_i[0]) ||
                      ((w_req_size == SZ_W) && (bus.req_addr_i[1:0] != 2'b00));
  assign w_req_err  = (w_req_size == SZ_RSV) || w_out_of_range || w_misalign;
  assign w_req_addr = bus.req_addr_i[ADDR_W+1:0];
`else
  assign w_req_err  = (w_req_size == SZ_RSV) || w_out_of_range;
  // Misalignment is silently corrected by clearing the low offset bits.
  always_comb begin
    w_req_addr = bus.req_addr_i[ADDR_W+1:0];
    if (w_req_size == SZ_H) w_req_addr[0]   = 1'b0;
    if (w_req_size == SZ_W) w_req_addr[1:0] = 2'b00;
  end
`endif

  // Lane logic always looks at the live memory word at the latched address;
  // in RD that is exactly the word being loaded or merged.
  lsu_align u_align (
    .word_i  (bus.mem_rdata_i),
    .wdata_i (wlo_q),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .load_o  (w_load),
    .merge_o (w_merge)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wlo_d   = wlo_q;
    wword_d = wword_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          addr_d  = w_req_addr;
          size_d  = w_req_size;
          we_d    = bus.req_we_i;
          uns_d   = bus.req_unsigned_i;
          err_d   = w_req_err;
          wlo_d   = bus.req_wdata_i[15:0];
          wword_d = bus.req_wdata_i;
          // Stores and errors respond with zero data.
          rdata_d = '0;
          if (w_req_err)                                state_d = ST_RESP;
          else if (bus.req_we_i && (w_req_size == SZ_W)) state_d = ST_WR;
          else                                          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (we_q) begin
          wword_d = w_merge;
          state_d = ST_WR;
        end else begin
          rdata_d = w_load;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_B;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wlo_q   <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wlo_q   <= wlo_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.mem_addr_o  = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata_o = wword_q;
  // Reset suppresses the write even when it lands during WR.
  assign bus.mem_wren_o  = (state_q == ST_WR) && !rst_i;

endmodule : lsu_mem_master
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_master
//  Purpose  : Directed self-checking bench for lsu_mem_master with a
//             behavioural async-read word memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_master;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   wr_count;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  lsu_mem_master_if #(.ADDR_W(10)) bus ();

  lsu_mem_master #(.ADDR_W(10), .XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o];

  initial wr_count = 0;
  always @(posedge clk) begin
    if (bus.mem_wren_o) begin
      mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      wr_count <= wr_count + 1;
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One transaction: drive, accept, watch up to 8 cycles, check outcome.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_wr_n, input logic [9:0] exp_wa);
    int          lat;
    int          wr_n;
    logic [31:0] rd;
    logic        er;
    logic [9:0]  wa;
    @(negedge clk);
    check_val({tag, "_ready"}, {31'h0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = sz;
    bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wd;
    @(posedge clk);
    lat = 99; wr_n = 0; wa = '0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid_i = 1'b0;
      if (bus.mem_wren_o) begin
        wr_n = n;
        wa   = bus.mem_addr_o;
      end
      if (bus.rsp_valid_o) begin
        lat = n;
        rd  = bus.rsp_rdata_o;
        er  = bus.rsp_err_o;
        break;
      end
    end
    bus.req_valid_i = 1'b0;
    check_val({tag, "_lat"},   lat, exp_lat);
    check_val({tag, "_rdata"}, rd, exp_rd);
    check_val({tag, "_err"},   {31'h0, er}, {31'h0, exp_err});
    check_val({tag, "_wr_cyc"}, wr_n, exp_wr_n);
    if (exp_wr_n != 0) check_val({tag, "_wr_addr"}, {22'h0, wa}, {22'h0, exp_wa});
  endtask

  initial begin
    int wc;
    int last_acc;
    int n_acc;
    logic prev_rsp;
    n_total = 0; n_bad = 0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'h0, bus.req_ready_o}, 32'd1);
    check_val("rst_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'd0);
    check_val("rst_rsp_err", {31'h0, bus.rsp_err_o}, 32'd0);
    check_val("rst_wren", {31'h0, bus.mem_wren_o}, 32'd0);
    check_val("rst_rdata", bus.rsp_rdata_o, 32'd0);
    check_val("rst_mem_addr", {22'h0, bus.mem_addr_o}, 32'd0);
    check_val("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    rst = 1'b0;

    // Word store then word load.
    xact("sw", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 10'd4);
    check_val("sw_mem", mem[4], 32'hDEADBEEF);
    xact("lw", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 10'd0);

    // Sub-word stores (read-modify-write).
    preload(10'd4, 32'h11223344);
    xact("sb", 1'b1, 2'b00, 1'b0, 32'h012, 32'h123456AA, 3, 32'h0, 1'b0, 2, 10'd4);
    check_val("sb_mem", mem[4], 32'h11AA3344);
    preload(10'd5, 32'hCAFEF00D);
    xact("sh", 1'b1, 2'b01, 1'b0, 32'h016, 32'h9999BEEF, 3, 32'h0, 1'b0, 2, 10'd5);
    check_val("sh_mem", mem[5], 32'hBEEFF00D);

    // Signed / unsigned loads.
    preload(10'd4, 32'h0000F080);
    xact("lb",   1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 10'd0);
    xact("lbu",  1'b0, 2'b00, 1'b1, 32'h010, 32'h0, 2, 32'h00000080, 1'b0, 0, 10'd0);
    xact("lh",   1'b0, 2'b01, 1'b0, 32'h010, 32'h0, 2, 32'hFFFFF080, 1'b0, 0, 10'd0);
    xact("lhu",  1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 2, 32'h0000F080, 1'b0, 0, 10'd0);
    xact("lb1",  1'b0, 2'b00, 1'b0, 32'h011, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 0, 10'd0);
    xact("lbu3", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 2, 32'h00000000, 1'b0, 0, 10'd0);

    // Error cases: none may touch memory.
    wc = wr_count;
`ifdef LSU_MISALIGN_TRAP_EN
    xact("lw_mis", 1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 1, 32'h0, 1'b1, 0, 10'd0);
`else
    xact("lw_mis", 1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 2, 32'h0000F080, 1'b0, 0, 10'd0);
`endif
    xact("lw_oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 10'd0);
    xact("sw_oor", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h55555555, 1, 32'h0, 1'b1, 0, 10'd0);
    xact("rsv",    1'b1, 2'b11, 1'b0, 32'h010, 32'h55555555, 1, 32'h0, 1'b1, 0, 10'd0);
    check_val("err_no_write", wr_count, wc);
    check_val("err_mem4", mem[4], 32'h0000F080);

    // Reset in the WR cycle of a byte store.
    preload(10'd6, 32'h55667788);
    wc = wr_count;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h018; bus.req_wdata_i = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check_val("rrst_in_wr", {31'h0, bus.mem_wren_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rrst_ready", {31'h0, bus.req_ready_o}, 32'd1);
    check_val("rrst_rsp", {31'h0, bus.rsp_valid_o}, 32'd0);
    check_val("rrst_no_write", wr_count, wc);
    check_val("rrst_mem", mem[6], 32'h55667788);
    repeat (3) @(negedge clk);
    check_val("rrst_rsp_late", {31'h0, bus.rsp_valid_o}, 32'd0);

    // Back-to-back loads with valid held high.
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h010; bus.req_wdata_i = '0;
    last_acc = -1; n_acc = 0; prev_rsp = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.req_ready_o) begin
        if (last_acc >= 0) check_val("b2b_gap", c - last_acc, 3);
        last_acc = c;
        n_acc++;
      end
      if (bus.rsp_valid_o) begin
        check_val("b2b_rsp_run", {31'h0, prev_rsp}, 32'd0);
        check_val("b2b_rdata", bus.rsp_rdata_o, 32'h0000F080);
      end
      prev_rsp = bus.rsp_valid_o;
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    check_val("b2b_n_acc", n_acc, 7);
    for (int k = 0; k < 8 && !bus.req_ready_o; k++) @(negedge clk);
    check_val("b2b_drain", {31'h0, bus.req_ready_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_lsu_mem_master
`default_nettype wire
